// File: rtl/adc_serial_emulator_if.sv
// Serial pixel ADC bus: the ADC controller masters sclk/cs_n and reads sdata.
// The emulator sits on the slave side.
interface adc_serial_emulator_if;
    logic sclk;
    logic cs_n;
    logic sdata;

    modport master (output sclk, output cs_n, input sdata);
    modport slave  (input sclk, input cs_n, output sdata);
endinterface

// File: rtl/adc_serial_emulator.sv
// Stand-in for the Stonyman 12-bit serial pixel ADC: answers sclk/cs_n with deterministic pixels.
// Optional ADC_EMU_NOISE_EN adds LFSR noise on value bits [1:0].
module adc_serial_emulator #(
    parameter int          ROW_LEN   = 112,
    parameter logic [11:0] RAMP_STEP = 12'd1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enable,
    input  logic [1:0]                 mode,
    input  logic [11:0]                const_value,
    input  logic                       frame_sync,
    adc_serial_emulator_if.slave       bus,
    output logic                       conv_done,
    output logic [15:0]                conv_count,
    output logic [1:0]                 state_o
);

    localparam int CW = ($clog2(ROW_LEN) > 7) ? $clog2(ROW_LEN) : 7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [15:0]   shift_q, shift_d;
    logic [3:0]    idx_q, idx_d;
    logic          sdata_q, sdata_d;
    logic          conv_done_q;
    logic [15:0]   conv_count_q;
    logic [CW-1:0] row_q, col_q;
    logic [11:0]   ramp_q;
    logic          advance;
    logic [11:0]   value;

    // Synchronizers carry no reset so a chip select held low across reset
    // does not look like a fresh falling edge afterwards.
    logic sclk_s1, sclk_s2, sclk_s3;
    logic cs_s1, cs_s2, cs_s3;
    logic sclk_fall, cs_fall, cs_rise;

    always_ff @(posedge clk) begin
        sclk_s1 <= bus.sclk;
        sclk_s2 <= sclk_s1;
        sclk_s3 <= sclk_s2;
        cs_s1   <= bus.cs_n;
        cs_s2   <= cs_s1;
        cs_s3   <= cs_s2;
    end

    assign sclk_fall = sclk_s3 & ~sclk_s2;
    assign cs_fall   = cs_s3 & ~cs_s2;
    assign cs_rise   = ~cs_s3 & cs_s2;

`ifdef ADC_EMU_NOISE_EN
    logic [15:0] lfsr_q;
    logic        lfsr_fb;

    assign lfsr_fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];

    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr_q <= 16'hACE1;
        end else if (advance) begin
            lfsr_q <= {lfsr_q[14:0], lfsr_fb};
        end
    end
`endif

    always_comb begin
        value = const_value;
        case (mode)
            2'd0:    value = const_value;
            2'd1:    value = ramp_q;
            2'd2:    value = (row_q[3] ^ col_q[3]) ? const_value : 12'd0;
            default: value = {col_q[6:0], 5'b0};
        endcase
`ifdef ADC_EMU_NOISE_EN
        value = value ^ {10'd0, lfsr_q[1:0]};
`endif
    end

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        idx_d   = idx_q;
        advance = 1'b0;
        if (!enable) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cs_fall) begin
                        state_d = SHIFT;
                        shift_d = {4'd0, value};
                        idx_d   = 4'hF;
                    end
                end
                SHIFT: begin
                    // Chip-select rise wins over a coincident sclk fall: abort.
                    if (cs_rise) begin
                        state_d = IDLE;
                    end else if (sclk_fall && !cs_s2) begin
                        if (idx_q == 4'd0) begin
                            state_d = DONE;
                        end else begin
                            shift_d = {shift_q[14:0], 1'b0};
                            idx_d   = idx_q - 4'd1;
                        end
                    end
                end
                DONE: begin
                    if (cs_rise) begin
                        state_d = IDLE;
                        advance = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        sdata_d = (state_d == SHIFT) ? shift_d[15] : 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            shift_q      <= 16'd0;
            idx_q        <= 4'd0;
            sdata_q      <= 1'b0;
            conv_done_q  <= 1'b0;
            conv_count_q <= 16'd0;
            row_q        <= '0;
            col_q        <= '0;
            ramp_q       <= 12'd0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            idx_q       <= idx_d;
            sdata_q     <= sdata_d;
            conv_done_q <= advance;
            if (frame_sync) begin
                conv_count_q <= 16'd0;
                row_q        <= '0;
                col_q        <= '0;
                ramp_q       <= 12'd0;
            end else if (advance) begin
                conv_count_q <= conv_count_q + 16'd1;
                ramp_q       <= ramp_q + RAMP_STEP;
                if (col_q == CW'(ROW_LEN - 1)) begin
                    col_q <= '0;
                    row_q <= (row_q == CW'(ROW_LEN - 1)) ? '0 : row_q + CW'(1);
                end else begin
                    col_q <= col_q + CW'(1);
                end
            end
        end
    end

    assign bus.sdata  = sdata_q;
    assign conv_done  = conv_done_q;
    assign conv_count = conv_count_q;
    assign state_o    = state_q;

endmodule

// File: doc/adc_serial_emulator.md
# adc_serial_emulator

Synthesizable stand-in for the 12-bit serial pixel ADC behind each Stonyman camera. It responds to the ADC controller's `sclk`/`cs_n` bus and shifts out deterministic pixel values on `sdata`. It lets the imager capture path (ADC controller, framemask, pupil detect) run in simulation and on a board with no sensor attached. It is the slave end of the interface the ADC controller masters, selected per camera by a top-level mux.

## Interface
Parameters:
- `ROW_LEN`, 112: pixels per row; column counter wraps here, row counter wraps at ROW_LEN rows.
- `RAMP_STEP`, 1: increment per completed conversion in ramp mode (12-bit).

Ports:
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high.
- `enable` in 1: emulator active; low forces IDLE, `sdata`=0, counters frozen.
- `mode` in 2: 0 constant, 1 ramp, 2 checkerboard, 3 column gradient; sampled at `cs_n` fall.
- `const_value` in 12: constant/checkerboard level.
- `frame_sync` in 1: one-cycle pulse; clears row/col counters and ramp accumulator (ties to frame_capture_start).
- `sclk` in 1: serial clock from ADC controller, asynchronous to `clk`.
- `cs_n` in 1: chip select, active-low, asynchronous.
- `sdata` out 1: serial data, MSB first.
- `conv_done` out 1: one-cycle pulse per fully shifted conversion.
- `conv_count` out 16: completed conversions since reset/frame_sync, wraps at 65535->0.

## Operation
- `sclk` and `cs_n` pass through 2-FF synchronizers; edges are detected on the synchronized copies (third register).
- Frame word is 16 bits: 4 leading zeros, then the 12-bit value MSB first.
- States:
  - IDLE: `sdata`=0. On `cs_n` fall with `enable`=1: latch value per `mode`, load shift register, bit index=15, go SHIFT.
  - SHIFT: `sdata`=shift[15]. Each `sclk` fall: shift left, index-1. On the fall after index 0 is presented, go DONE.
  - DONE: `sdata`=0. On `cs_n` rise: pulse `conv_done`, `conv_count`+1, advance pixel/ramp state, go IDLE.
- `cs_n` rise during SHIFT (abort): go IDLE, no `conv_done`, counters unchanged.
- `sclk` edges while `cs_n` is high are ignored.
- Value generation:
  - Mode 0: `const_value`.
  - Mode 1: ramp accumulator, +`RAMP_STEP` modulo 4096 per conversion.
  - Mode 2: `const_value` when row[3]^col[3]=1, else 0 (8x8 blocks).
  - Mode 3: {col[6:0],5'b0}.
- Pixel advance: col+1; at col=ROW_LEN-1, col=0 and row+1; at row=ROW_LEN-1 with that wrap, row=0.
- `frame_sync` has priority over a same-cycle advance: the counters end at 0.
- `enable` fall mid-frame behaves like an abort.
- Reset values: `sdata`=0, `conv_done`=0, `conv_count`=0, state IDLE, row=col=ramp=0.

## Timing
- `sdata` changes 3 `clk` cycles after a pin-level `cs_n` fall or `sclk` fall (2 sync + 1 output register). The output is registered with no combinational path from inputs.
- Each `sclk` high and low phase must be at least 4 `clk` periods. The master samples `sdata` on `sclk` rise.
- `conv_done` asserts 3 cycles after the pin-level `cs_n` rise, for exactly 1 cycle.

## Configuration
- `ADC_EMU_NOISE_EN` defined: a 16-bit LFSR (x^16+x^14+x^13+x^11+1, seed 16'hACE1 at reset) steps once per conversion. Its 2 LSBs are XORed into value bits [1:0] at latch time.
- Undefined: no LFSR is built and values are exactly as listed above.

## Test plan
- Mode 0, `const_value`=12'hA5C, one 16-sclk frame -> bits 0000_1010_0101_1100, `conv_done` pulse, `conv_count`=1.
- Mode 1, `RAMP_STEP`=1, 4097 frames after `frame_sync` -> frame 4096 reads 12'hFFF, frame 4097 reads 12'h000.
- Mode 2, `const_value`=12'hFFF, ROW_LEN=112 -> pixels 0-7 read 0, pixel 8 reads FFF; row 8 col 0 reads FFF; after 112*112 frames row/col are back to 0.
- `cs_n` rises after 7 sclk falls, then a full frame in mode 1 -> no `conv_done` for the aborted frame, and the full frame returns the unadvanced ramp value.
- `reset` asserted mid-SHIFT -> next cycle `sdata`=0, `conv_count`=0, state IDLE; the next frame is correct.
- `enable`=0 with active `cs_n`/`sclk` -> `sdata` stays 0 and `conv_count` does not change.
